// File: rtl/camellia_stream_scheduler.sv
// camellia_stream_scheduler
// Shares one fully pipelined Camellia-128 core among NUM_REQ requesters.
// Blocks are issued one per cycle by round-robin arbitration. Each issued block
// carries its requester ID down a LAT-deep shadow pipeline so that every result
// leaves with its owner's ID. Key changes stop issue, drain the core, load the
// new key and wait KEY_LAT cycles for the key schedule before issue resumes.
// Optional build macro: CAM_SCHED_STRICT_PRIO_EN selects fixed priority
// (requester 0 highest) instead of round-robin.
module camellia_stream_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int LAT     = 20,
    parameter int KEY_LAT = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*128-1:0] req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [127:0]           key_in,
    input  logic                   key_load,
    output logic                   key_ack,
    output logic [127:0]           core_M,
    output logic                   core_valid,
    output logic [127:0]           core_KL,
    input  logic [127:0]           core_C,
    output logic                   res_valid,
    output logic [ID_W-1:0]        res_id,
    output logic [127:0]           res_data,
    output logic                   busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_KSETUP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [127:0]    core_m_q, core_m_d;
    logic [127:0]    core_kl_q, core_kl_d;
    logic            core_valid_q, core_valid_d;
    logic [LAT-1:0]  tag_v_q, tag_v_d;
    logic [ID_W-1:0] tag_id_q [LAT];
    logic [ID_W-1:0] tag_id_d [LAT];
    logic            res_valid_q, res_valid_d;
    logic [ID_W-1:0] res_id_q, res_id_d;
`ifndef CAM_SCHED_STRICT_PRIO_EN
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
`endif

    logic [127:0]     req_word [NUM_REQ];
    logic             issue_en;
    logic             grant_found;
    logic [PTR_W-1:0] grant_ptr;
    logic [PTR_W-1:0] scan_ptr;
    logic [ID_W-1:0]  grant_id;
    logic             in_flight;

    // Split the flat plaintext bus into one word per requester.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_word
            assign req_word[gi] = req_data[128*gi +: 128];
        end
    endgenerate

    // A pending key change takes priority over any request in the same cycle.
    assign issue_en  = (state_q == ST_RUN) && !key_load;
    assign in_flight = |tag_v_q;
    assign grant_id  = ID_W'(grant_ptr);

    // Arbiter: first valid requester found scanning upward from the start point.
    always_comb begin
        grant_found = 1'b0;
        grant_ptr   = '0;
        scan_ptr    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef CAM_SCHED_STRICT_PRIO_EN
            scan_ptr = PTR_W'(k);
`else
            scan_ptr = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
`endif
            if (issue_en && !grant_found && req_valid[scan_ptr]) begin
                grant_found = 1'b1;
                grant_ptr   = scan_ptr;
            end
        end
    end

    assign req_ready = grant_found ? (NUM_REQ'(1) << grant_ptr) : '0;

    // Tag shadow pipeline: stage 0 loads alongside core_M, then shifts each cycle.
    assign tag_v_d[0]  = grant_found;
    assign tag_id_d[0] = grant_id;
    generate
        for (gi = 1; gi < LAT; gi++) begin : g_tag
            assign tag_v_d[gi]  = tag_v_q[gi-1];
            assign tag_id_d[gi] = tag_id_q[gi-1];
        end
    endgenerate

    // Issue datapath, result tag and key sequencing next-state logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        core_kl_d    = core_kl_q;
        core_valid_d = grant_found;
        core_m_d     = grant_found ? req_word[grant_ptr] : core_m_q;
        res_valid_d  = tag_v_q[LAT-1];
        res_id_d     = tag_id_q[LAT-1];
        key_ack      = 1'b0;
`ifndef CAM_SCHED_STRICT_PRIO_EN
        rr_ptr_d     = grant_found ? PTR_W'((int'(grant_ptr) + 1) % NUM_REQ) : rr_ptr_q;
`endif
        case (state_q)
            ST_RUN: begin
                if (key_load) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Only swap the key once every tagged block has left the core.
                if (!in_flight) begin
                    core_kl_d = key_in;
                    cnt_d     = '0;
                    state_d   = ST_KSETUP;
                end
            end
            ST_KSETUP: begin
                if (cnt_q == 4'(KEY_LAT - 1)) begin
                    key_ack = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State and pipeline registers; reset discards everything in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_RUN;
            cnt_q        <= '0;
            core_m_q     <= '0;
            core_kl_q    <= '0;
            core_valid_q <= 1'b0;
            tag_v_q      <= '0;
            res_valid_q  <= 1'b0;
            res_id_q     <= '0;
`ifndef CAM_SCHED_STRICT_PRIO_EN
            rr_ptr_q     <= '0;
`endif
            for (int s = 0; s < LAT; s++) begin
                tag_id_q[s] <= '0;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            core_m_q     <= core_m_d;
            core_kl_q    <= core_kl_d;
            core_valid_q <= core_valid_d;
            tag_v_q      <= tag_v_d;
            res_valid_q  <= res_valid_d;
            res_id_q     <= res_id_d;
`ifndef CAM_SCHED_STRICT_PRIO_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
            for (int s = 0; s < LAT; s++) begin
                tag_id_q[s] <= tag_id_d[s];
            end
        end
    end

    assign core_M     = core_m_q;
    assign core_valid = core_valid_q;
    assign core_KL    = core_kl_q;
    assign res_valid  = res_valid_q;
    assign res_id     = res_id_q;
    assign res_data   = core_C;
    assign busy       = in_flight || (state_q != ST_RUN);

endmodule

// File: doc/camellia_stream_scheduler.md
Name: camellia_stream_scheduler

Overview:
- Shares one fully pipelined Camellia-128 encryption core among NUM_REQ requesters.
- Round-robin arbitration; at most one block issued to the core per cycle.
- Tags each issued block with its requester ID through a LAT-deep shadow pipeline, so each ciphertext returns with its owner's ID.
- Sequences key changes: stops issue, drains the core, loads the new key, waits for the key schedule to settle, then resumes.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- ID_W, 2: requester ID width; must be at least clog2(NUM_REQ).
- LAT, 20: core latency in cycles, from core_M/core_valid presented to the matching core_C valid (1..64).
- KEY_LAT, 4: cycles after core_KL changes before the core key schedule is stable (1..15).

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester block valid.
- req_data  in  NUM_REQ*128  per-requester plaintext; requester i uses bits [128*i+127 : 128*i].
- req_ready  out  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- key_in  in  128  new key.
- key_load  in  1  level request to change key; held until key_ack.
- key_ack  out  1  one-cycle pulse: new key is in effect.
- core_M  out  128  plaintext to the core; registered.
- core_valid  out  1  drives the core's data_valid; registered.
- core_KL  out  128  key to the core; registered.
- core_C  in  128  ciphertext from the core.
- res_valid  out  1  result valid. No backpressure; the consumer must accept it.
- res_id  out  ID_W  requester ID for the result.
- res_data  out  128  result data; combinational pass-through of core_C.
- busy  out  1  high when any block is in flight or state != RUN.

Behaviour:
- Reset (RST=0, asynchronous):
  - state=RUN, rr_ptr=0.
  - core_M=0, core_valid=0, core_KL=0.
  - all tag stages cleared; res_valid=0, res_id=0.
  - key_ack=0, busy=0.
  - Reset mid-operation discards all in-flight blocks; none of them produces res_valid.
- Arbitration (RUN with key_load=0):
  - Scan from rr_ptr upward, wrapping at NUM_REQ-1 → 0. Grant the first i with req_valid[i]=1.
  - req_ready is combinational, at most one bit high, and all zero when no requester is valid.
  - On transfer of i: next cycle core_M=req_data[i] and core_valid=1; rr_ptr ← (i+1) mod NUM_REQ.
  - Without a transfer: core_valid=0 next cycle; core_M holds its value; rr_ptr holds.
  - Sustained throughput is 1 block/cycle.
- Tag pipeline:
  - Stage 0 loads {core_valid, granted ID} in the same cycle core_M is registered.
  - The tag shifts once per cycle.
  - res_valid/res_id appear exactly LAT cycles after the matching core_valid, aligned with core_C.
  - in_flight = OR of all tag-stage valid bits.
- State machine:
  - RUN:
    - Normal issue.
    - If key_load=1: req_ready=0 in that same cycle (the key has priority over simultaneous requests); go to DRAIN.
  - DRAIN:
    - req_ready=0, core_valid=0.
    - Results keep emerging.
    - When in_flight=0 (evaluated registered): core_KL ← key_in, clear the settle counter, go to KSETUP.
    - If nothing is in flight on entry, DRAIN lasts exactly 1 cycle.
  - KSETUP:
    - req_ready=0; counter increments each cycle.
    - When counter=KEY_LAT-1: key_ack=1 for one cycle and return to RUN.
    - key_load is ignored here.
    - If key_load is still high in the first RUN cycle, a new key change starts; the requester must drop key_load on key_ack.
- No blocks are lost or reordered. Results exit in issue order; every issued block produces exactly one res_valid.
- Key switch costs (remaining in-flight cycles + 1 + KEY_LAT) cycles of no issue.

Optional Feature:
- CAM_SCHED_STRICT_PRIO_EN
  - Defined: fixed priority, requester 0 highest and NUM_REQ-1 lowest; rr_ptr is removed and may starve high-index requesters.
  - Undefined (default): round-robin as described above.

Test Plan:
1. Reset, then requester 2 valid with data 0x0123...CDEF (128 bits) held 1 cycle → req_ready=4'b0100. Next cycle core_valid=1, core_M=that data. res_valid=1 with res_id=2 exactly LAT=20 cycles later.
2. All 4 requesters valid continuously for 8 cycles from reset → grant order 0,1,2,3,0,1,2,3. core_valid high 8 consecutive cycles. Results return with ids 0,1,2,3,0,1,2,3 on consecutive cycles.
3. Stream 5 blocks, raise key_load one cycle after the last issue → DRAIN for the ~19 remaining in-flight cycles, 5 results delivered. core_KL=key_in on exit from DRAIN. key_ack pulses 4 cycles later. No req_ready during this whole interval.
4. key_load and req_valid=4'b1111 in the same RUN cycle → req_ready=0 that cycle, no issue. Idle pipeline: key_ack at cycle +5 (1 DRAIN + 4 KSETUP).
5. Assert RST low with 10 blocks in flight → all outputs zero immediately. After release, no res_valid appears over 40 cycles without new requests.
6. With CAM_SCHED_STRICT_PRIO_EN, requesters 0 and 3 continuously valid → requester 0 granted every cycle; requester 3 never granted.
